// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and valid/ready on both sides.
// Optional feature: define ZICSR_IMM_EN to emit zero-extended CSR zimm (type Z) for SYSTEM.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_flush,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_imm_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] TypeNone    = 3'd0;
  localparam logic [2:0] TypeI       = 3'd1;
  localparam logic [2:0] TypeS       = 3'd2;
  localparam logic [2:0] TypeB       = 3'd3;
  localparam logic [2:0] TypeU       = 3'd4;
  localparam logic [2:0] TypeJ       = 3'd5;
  localparam logic [2:0] TypeZ       = 3'd6;
  localparam logic [2:0] TypeIllegal = 3'd7;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StFull1, StFull2} state_e;

  state_e state_q;
  entry_t main_q;
  entry_t skid_q;
  entry_t dec;
  logic   valid_q;
  logic   ready_q;
  logic   accept;
  logic   drain;

  logic [31:0] imm32;

  // Every format's bit 31 equals inst[31] (zimm has it clear), so the XLEN
  // extension can always replicate imm32[31].
  always_comb begin
    imm32       = '0;
    dec.typ     = TypeNone;
    dec.illegal = 1'b0;
    dec.tag     = in_tag;
    case (in_inst[6:0])
      OpReg: begin
        imm32   = '0;
        dec.typ = TypeNone;
      end
      OpImm, OpLoad, OpJalr, OpMisc: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.typ = TypeI;
      end
      OpStore: begin
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec.typ = TypeS;
      end
      OpBranch: begin
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        dec.typ = TypeB;
      end
      OpLui, OpAuipc: begin
        imm32   = {in_inst[31:12], 12'h000};
        dec.typ = TypeU;
      end
      OpJal: begin
        imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
        dec.typ = TypeJ;
      end
      OpSystem: begin
`ifdef ZICSR_IMM_EN
        if (in_inst[14]) begin
          imm32   = {27'd0, in_inst[19:15]};
          dec.typ = TypeZ;
        end else begin
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
          dec.typ = TypeI;
        end
`else
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        dec.typ = TypeI;
`endif
      end
      default: begin
        imm32       = '0;
        dec.typ     = TypeIllegal;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
  end

  assign accept = in_valid & ready_q;
  assign drain  = valid_q & in_ready;

  // ready_q is low exactly in StFull2, so no accept can reach that state.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= StEmpty;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (in_flush) begin
      state_q <= StEmpty;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= dec;
            valid_q <= 1'b1;
            state_q <= StFull1;
          end
        end
        StFull1: begin
          if (accept && drain) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q  <= dec;
            ready_q <= 1'b0;
            state_q <= StFull2;
          end else if (drain) begin
            valid_q <= 1'b0;
            state_q <= StEmpty;
          end
        end
        StFull2: begin
          if (drain) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state_q <= StFull1;
          end
        end
        default: begin
          state_q <= StEmpty;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid    = valid_q;
  assign out_ready    = ready_q;
  assign out_imm      = main_q.imm;
  assign out_imm_type = main_q.typ;
  assign out_illegal  = main_q.illegal;
  assign out_tag      = main_q.tag;

endmodule
